// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle ops (add/sub/logic/compare/shift) complete one cycle after accept.
// Iterative ops (multiply and unsigned divide) run a bit-serial datapath for WL
// cycles in CALC. Results are held in DONE until the consumer takes them.

module mc_alu #(
  parameter int unsigned WL = 32,
  parameter int unsigned SL = 5
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] SrcA,
  input  logic [WL-1:0] SrcB,
  input  logic [SL-1:0] sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] Out,
  output logic          Zero,
  output logic          Ovf,
  output logic          Err
);

  localparam int unsigned ShW  = $clog2(WL);
  localparam int unsigned CntW = $clog2(WL) + 1;

  localparam logic [SL-1:0] OpAdd   = SL'(0);
  localparam logic [SL-1:0] OpSub   = SL'(1);
  localparam logic [SL-1:0] OpAnd   = SL'(2);
  localparam logic [SL-1:0] OpOr    = SL'(3);
  localparam logic [SL-1:0] OpXor   = SL'(4);
  localparam logic [SL-1:0] OpSlt   = SL'(5);
  localparam logic [SL-1:0] OpSll   = SL'(6);
  localparam logic [SL-1:0] OpSra   = SL'(7);
  localparam logic [SL-1:0] OpMul   = SL'(16);
  localparam logic [SL-1:0] OpMulhu = SL'(17);
  localparam logic [SL-1:0] OpDivu  = SL'(18);
  localparam logic [SL-1:0] OpRemu  = SL'(19);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [WL-1:0]      a_q;
  logic [WL-1:0]      b_q;
  logic [SL-1:0]      op_q;
  // Shared accumulator: {product_hi, multiplier/product_lo} for multiply,
  // {partial remainder, dividend/quotient} for divide.
  logic [2*WL-1:0]    acc_q;
  logic [2*WL-1:0]    acc_nx;

  // ---------------------------------------------------------------------------
  // Single-cycle result path, decoded straight from the request inputs
  // ---------------------------------------------------------------------------
  logic [WL-1:0]  sum;
  logic [WL-1:0]  diff;
  logic [WL-1:0]  sc_res;
  logic [ShW-1:0] shamt;
  logic           sc_ovf;
  logic           sc_err;
  logic           is_iter;

  assign sum   = SrcA + SrcB;
  assign diff  = SrcA - SrcB;
  assign shamt = SrcB[ShW-1:0];

  // Decode the op code into a single-cycle result, overflow and error flags
  always_comb begin
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_err  = 1'b0;
    is_iter = 1'b0;
    case (sel)
      OpAdd: begin
        sc_res = sum;
        sc_ovf = (SrcA[WL-1] == SrcB[WL-1]) && (sum[WL-1] != SrcA[WL-1]);
      end
      OpSub: begin
        sc_res = diff;
        sc_ovf = (SrcA[WL-1] != SrcB[WL-1]) && (diff[WL-1] != SrcA[WL-1]);
      end
      OpAnd: sc_res = SrcA & SrcB;
      OpOr:  sc_res = SrcA | SrcB;
      OpXor: sc_res = SrcA ^ SrcB;
      OpSlt: sc_res = {{(WL-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OpSll: sc_res = SrcA << shamt;
      OpSra: sc_res = $signed(SrcA) >>> shamt;
      OpMul, OpMulhu, OpDivu, OpRemu: is_iter = 1'b1;
      default: sc_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath: one multiplier bit or one quotient bit per cycle
  // ---------------------------------------------------------------------------
  logic          is_mul;
  logic [WL:0]   mul_hi;
  logic [WL:0]   div_sh;
  logic [WL-1:0] div_trial;
  logic [WL-1:0] div_rem;
  logic          div_ge;

  assign is_mul = (op_q == OpMul) || (op_q == OpMulhu);

  // Compute the next accumulator value for one shift-add or restoring-divide step
  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    mul_hi    = {1'b0, acc_q[2*WL-1:WL]} + (acc_q[0] ? {1'b0, a_q} : {(WL+1){1'b0}});
    // Restoring divide: shift the next dividend bit into the remainder, try
    // subtracting the divisor, keep the difference only if it did not go negative.
    div_sh    = acc_q[2*WL-1:WL-1];
    div_ge    = div_sh >= {1'b0, b_q};
    div_trial = div_sh[WL-1:0] - b_q;
    div_rem   = div_ge ? div_trial : div_sh[WL-1:0];
    if (is_mul) begin
      acc_nx = {mul_hi, acc_q[WL-1:1]};
    end else begin
      acc_nx = {div_rem, acc_q[WL-2:0], div_ge};
    end
  end

  logic [WL-1:0] it_res;
  logic          it_err;
  logic          b_zero;

  assign b_zero = (b_q == '0);

  // Select the iterative result from the final accumulator, overriding on divide-by-zero
  always_comb begin
    it_res = acc_nx[WL-1:0];
    it_err = 1'b0;
    case (op_q)
      OpMulhu: it_res = acc_nx[2*WL-1:WL];
      OpDivu: begin
        it_err = b_zero;
        if (b_zero) it_res = '1;
      end
      OpRemu: begin
        it_err = b_zero;
        it_res = b_zero ? a_q : acc_nx[2*WL-1:WL];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered result outputs
  // ---------------------------------------------------------------------------
  // Sequence IDLE -> (CALC) -> DONE and load the result registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      Out     <= '0;
      Zero    <= 1'b0;
      Ovf     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (is_iter) begin
              state_q <= StCalc;
              a_q     <= SrcA;
              b_q     <= SrcB;
              op_q    <= sel;
              cnt_q   <= CntW'(WL);
              // Multiply shifts the multiplier out of the low half; divide
              // shifts the dividend out of it.
              if ((sel == OpMul) || (sel == OpMulhu)) begin
                acc_q <= {{WL{1'b0}}, SrcB};
              end else begin
                acc_q <= {{WL{1'b0}}, SrcA};
              end
            end else begin
              state_q <= StDone;
              Out     <= sc_res;
              Zero    <= (sc_res == '0);
              Ovf     <= sc_ovf;
              Err     <= sc_err;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_nx;
          cnt_q <= cnt_q - CntW'(1);
          // Last step: the counter reaches zero on this edge.
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
            Out     <= it_res;
            Zero    <= (it_res == '0);
            Ovf     <= 1'b0;
            Err     <= it_err;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu (WL=32): directed vector table, hold and
// reset sequences, then random requests against an arithmetic reference model.

module tb_mc_alu;

  logic        CLK;
  logic        RSTn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out;
  logic        Zero;
  logic        Ovf;
  logic        Err;

  mc_alu #(.WL(32), .SL(5)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .Zero      (Zero),
    .Ovf       (Ovf),
    .Err       (Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [4:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic        z;
    logic        ov;
    logic        er;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  // Reference model: plain wide arithmetic on the operation's definition.
  function automatic void ref_model(input logic [4:0] s, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] o,
                                    output logic ov, output logic er, output int lat);
    longint      sa;
    longint      sb;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o = '0; ov = 1'b0; er = 1'b0; lat = 1; r = 0; p = '0;
    case (s)
      5'd0: begin
        r = sa + sb; o = r[31:0];
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      5'd1: begin
        r = sa - sb; o = r[31:0];
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      5'd2: o = a & b;
      5'd3: o = a | b;
      5'd4: o = a ^ b;
      5'd5: o = (sa < sb) ? 32'd1 : 32'd0;
      5'd6: begin p = {32'b0, a} * (64'd1 << b[4:0]); o = p[31:0]; end
      5'd7: begin r = sa >>> b[4:0]; o = r[31:0]; end
      5'd16: begin p = {32'b0, a} * {32'b0, b}; o = p[31:0]; lat = 33; end
      5'd17: begin p = {32'b0, a} * {32'b0, b}; o = p[63:32]; lat = 33; end
      5'd18: begin
        lat = 33;
        if (b == 0) begin o = 32'hFFFF_FFFF; er = 1'b1; end
        else o = a / b;
      end
      5'd19: begin
        lat = 33;
        if (b == 0) begin o = a; er = 1'b1; end
        else o = a % b;
      end
      default: er = 1'b1;
    endcase
  endfunction

  // Issue one request, measure accept-to-valid latency (accept edge counts as 1),
  // optionally stall the consumer for `hold` cycles, then complete the transfer.
  task automatic do_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input logic [31:0] exp_o,
                       output logic [31:0] o, output logic z, output logic ov,
                       output logic er, output int lat);
    int w;
    w = 0;
    @(negedge CLK);
    while (!in_ready && w < 100) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 100) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    SrcA      = a;
    SrcB      = b;
    sel       = s;
    out_ready = (hold == 0);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    SrcA     = $urandom;
    SrcB     = $urandom;
    sel      = 5'($urandom);
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    o = Out; z = Zero; ov = Ovf; er = Err;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge CLK);
        #1;
        chk("hold_out", 64'(Out), 64'(exp_o));
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("hold_out_valid", 64'(out_valid), 64'd1);
      end
      @(negedge CLK);
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      chk("release_out_valid", 64'(out_valid), 64'd0);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
    end
  endtask

  logic [31:0] r_o;
  logic        r_z;
  logic        r_ov;
  logic        r_er;
  int          r_lat;
  logic [31:0] e_o;
  logic        e_ov;
  logic        e_er;
  int          e_lat;
  logic [4:0]  codes[14];
  logic        seen_valid;

  initial begin
    vecs[0]  = '{5'd0,  32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{5'd1,  32'd5,         32'd5,        32'h0,         1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{5'd5,  32'hFFFF_FFFF, 32'h0,        32'h1,         1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,        1'b0, 1'b0, 1'b0, 33};
    vecs[4]  = '{5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33};
    vecs[5]  = '{5'd18, 32'd100,       32'd7,        32'd14,        1'b0, 1'b0, 1'b0, 33};
    vecs[6]  = '{5'd19, 32'd100,       32'd7,        32'd2,         1'b0, 1'b0, 1'b0, 33};
    vecs[7]  = '{5'd18, 32'd5,         32'd0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 33};
    vecs[8]  = '{5'd19, 32'd1234,      32'd0,        32'd1234,      1'b0, 1'b0, 1'b1, 33};
    vecs[9]  = '{5'd31, 32'h1234,      32'h5678,     32'h0,         1'b1, 1'b0, 1'b1, 1};
    vecs[10] = '{5'd1,  32'h8000_0000, 32'h1,        32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[11] = '{5'd6,  32'h1,         32'h25,       32'h20,        1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{5'd7,  32'h8000_0000, 32'hFFFF_FF24, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{5'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{5'd4,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0,        1'b1, 1'b0, 1'b0, 1};
    vecs[16] = '{5'd0,  32'hFFFF_FFFF, 32'h1,        32'h0,         1'b1, 1'b0, 1'b0, 1};
    vecs[17] = '{5'd8,  32'h5,         32'h6,        32'h0,         1'b1, 1'b0, 1'b1, 1};

    codes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
              5'd16, 5'd17, 5'd18, 5'd19, 5'd9, 5'd20};

    in_valid = 1'b0; out_ready = 1'b0; SrcA = '0; SrcB = '0; sel = '0;
    RSTn = 1'b0;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out", 64'(Out), 64'd0);
    chk("reset_flags", 64'({Zero, Ovf, Err}), 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, 0, vecs[i].o, r_o, r_z, r_ov, r_er, r_lat);
      chk($sformatf("vec%0d_out", i), 64'(r_o), 64'(vecs[i].o));
      chk($sformatf("vec%0d_zero", i), 64'(r_z), 64'(vecs[i].z));
      chk($sformatf("vec%0d_ovf", i), 64'(r_ov), 64'(vecs[i].ov));
      chk($sformatf("vec%0d_err", i), 64'(r_er), 64'(vecs[i].er));
      chk($sformatf("vec%0d_lat", i), 64'(r_lat), 64'(vecs[i].lat));
    end

    // Consumer stall of 10 cycles in DONE
    do_op(5'd0, 32'd40, 32'd2, 10, 32'd42, r_o, r_z, r_ov, r_er, r_lat);
    chk("hold_result", 64'(r_o), 64'd42);
    chk("hold_lat", 64'(r_lat), 64'd1);

    // Reset in the middle of a divide
    do_op(5'd0, 32'd1, 32'd1, 0, 32'd2, r_o, r_z, r_ov, r_er, r_lat);
    chk("pre_reset_out", 64'(r_o), 64'd2);
    @(negedge CLK);
    in_valid = 1'b1; SrcA = 32'd1000; SrcB = 32'd3; sel = 5'd18; out_ready = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_out", 64'(Out), 64'd0);
    chk("midreset_err", 64'(Err), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK);
    RSTn = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("no_valid_after_reset", 64'(seen_valid), 64'd0);
    do_op(5'd0, 32'd2, 32'd3, 0, 32'd5, r_o, r_z, r_ov, r_er, r_lat);
    chk("post_reset_add", 64'(r_o), 64'd5);

    // Random requests against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [4:0]  s;
      logic [31:0] a;
      logic [31:0] b;
      s = codes[$urandom_range(0, 13)];
      a = $urandom;
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      if (s >= 5'd18 && $urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      ref_model(s, a, b, e_o, e_ov, e_er, e_lat);
      do_op(s, a, b, 0, e_o, r_o, r_z, r_ov, r_er, r_lat);
      chk($sformatf("rnd%0d_s%0d_out", i, s), 64'(r_o), 64'(e_o));
      chk($sformatf("rnd%0d_s%0d_zero", i, s), 64'(r_z), 64'(e_o == 0));
      chk($sformatf("rnd%0d_s%0d_ovf", i, s), 64'(r_ov), 64'(e_ov));
      chk($sformatf("rnd%0d_s%0d_err", i, s), 64'(r_er), 64'(e_er));
      chk($sformatf("rnd%0d_s%0d_lat", i, s), 64'(r_lat), 64'(e_lat));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
